// File: rtl/ray_bounce_scheduler.sv
// Ray bounce scheduler: issues primary rays for a frame, reissues hit rays for further
// bounces with priority, and retires rays on a miss or when they reach the bounce limit.
module ray_bounce_scheduler #(
  parameter int unsigned TAG_W        = 16,
  parameter int unsigned MAX_BOUNCES  = 4,
  parameter int unsigned MAX_INFLIGHT = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [TAG_W-1:0] num_rays,
  input  logic             ret_valid,
  input  logic [TAG_W-1:0] ret_tag,
  input  logic [3:0]       ret_bounce,
  input  logic             ret_hit,
  output logic             issue_valid,
  output logic [TAG_W-1:0] issue_tag,
  output logic [3:0]       issue_bounce,
  output logic             issue_primary,
  output logic             retire_valid,
  output logic [TAG_W-1:0] retire_tag,
  output logic             retire_miss,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = TAG_W + 1;
  localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [INF_W-1:0] inflight_q, inflight_d;

  logic             issue_valid_d, issue_primary_d;
  logic [TAG_W-1:0] issue_tag_d;
  logic [3:0]       issue_bounce_d;
  logic             retire_valid_d, retire_miss_d;
  logic [TAG_W-1:0] retire_tag_d;
  logic             done_d;

  logic [4:0]       next_bounce;
  logic             active_ret, reissue, retire, primary;

  // Returns outside a frame are stale and dropped.
  assign next_bounce = {1'b0, ret_bounce} + 5'd1;
  assign active_ret  = ret_valid && (state != IDLE);
  assign reissue     = active_ret && ret_hit && (next_bounce < 5'(MAX_BOUNCES));
  assign retire      = active_ret && !reissue;
  assign primary     = (state == RUN) && !reissue && (issued_q < num_q) &&
                       (inflight_q < INF_W'(MAX_INFLIGHT));

  assign busy = (state != IDLE);

  always_comb begin
    state_d         = state;
    num_d           = num_q;
    issued_d        = issued_q;
    retired_d       = retired_q;
    inflight_d      = inflight_q;
    issue_valid_d   = 1'b0;
    issue_tag_d     = issue_tag;
    issue_bounce_d  = issue_bounce;
    issue_primary_d = issue_primary;
    retire_valid_d  = 1'b0;
    retire_tag_d    = retire_tag;
    retire_miss_d   = retire_miss;
    done_d          = 1'b0;

    if (reissue) begin
      issue_valid_d   = 1'b1;
      issue_tag_d     = ret_tag;
      issue_bounce_d  = next_bounce[3:0];
      issue_primary_d = 1'b0;
    end else if (primary) begin
      issue_valid_d   = 1'b1;
      issue_tag_d     = issued_q[TAG_W-1:0];
      issue_bounce_d  = 4'd0;
      issue_primary_d = 1'b1;
      issued_d        = issued_q + CNT_W'(1);
    end

    if (retire) begin
      retire_valid_d = 1'b1;
      retire_tag_d   = ret_tag;
      retire_miss_d  = !ret_hit;
      retired_d      = retired_q + CNT_W'(1);
    end

    // A primary issue and a retirement in the same cycle cancel out.
    if (primary && !retire) begin
      inflight_d = inflight_q + INF_W'(1);
    end else if (!primary && retire) begin
      inflight_d = inflight_q - INF_W'(1);
    end

    case (state)
      IDLE: begin
        if (start) begin
          if (num_rays != '0) begin
            num_d      = {1'b0, num_rays};
            issued_d   = '0;
            retired_d  = '0;
            inflight_d = '0;
            state_d    = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issued_q == num_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (retired_q == num_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      num_q         <= '0;
      issued_q      <= '0;
      retired_q     <= '0;
      inflight_q    <= '0;
      issue_valid   <= 1'b0;
      issue_tag     <= '0;
      issue_bounce  <= '0;
      issue_primary <= 1'b0;
      retire_valid  <= 1'b0;
      retire_tag    <= '0;
      retire_miss   <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      num_q         <= num_d;
      issued_q      <= issued_d;
      retired_q     <= retired_d;
      inflight_q    <= inflight_d;
      issue_valid   <= issue_valid_d;
      issue_tag     <= issue_tag_d;
      issue_bounce  <= issue_bounce_d;
      issue_primary <= issue_primary_d;
      retire_valid  <= retire_valid_d;
      retire_tag    <= retire_tag_d;
      retire_miss   <= retire_miss_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_ray_bounce_scheduler.sv
// Scoreboard bench for ray_bounce_scheduler: directed frames push expected issue/retire/done
// events with their cycle; a monitor pops and compares; a loop model returns rays after a latency.
module tb_ray_bounce_scheduler;
  localparam int unsigned TAG_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start_a, start_b;
  logic [TAG_W-1:0] num_rays;
  logic             ret_valid, ret_hit;
  logic [TAG_W-1:0] ret_tag;
  logic [3:0]       ret_bounce;

  logic             a_issue_valid, a_issue_primary, a_retire_valid, a_retire_miss, a_busy, a_done;
  logic [TAG_W-1:0] a_issue_tag, a_retire_tag;
  logic [3:0]       a_issue_bounce;
  logic             b_issue_valid, b_issue_primary, b_retire_valid, b_retire_miss, b_busy, b_done;
  logic [TAG_W-1:0] b_issue_tag, b_retire_tag;
  logic [3:0]       b_issue_bounce;

  ray_bounce_scheduler #(.TAG_W(TAG_W), .MAX_BOUNCES(4), .MAX_INFLIGHT(48)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .num_rays(num_rays),
    .ret_valid(ret_valid), .ret_tag(ret_tag), .ret_bounce(ret_bounce), .ret_hit(ret_hit),
    .issue_valid(a_issue_valid), .issue_tag(a_issue_tag), .issue_bounce(a_issue_bounce),
    .issue_primary(a_issue_primary), .retire_valid(a_retire_valid), .retire_tag(a_retire_tag),
    .retire_miss(a_retire_miss), .busy(a_busy), .done(a_done));

  ray_bounce_scheduler #(.TAG_W(TAG_W), .MAX_BOUNCES(4), .MAX_INFLIGHT(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .num_rays(num_rays),
    .ret_valid(ret_valid), .ret_tag(ret_tag), .ret_bounce(ret_bounce), .ret_hit(ret_hit),
    .issue_valid(b_issue_valid), .issue_tag(b_issue_tag), .issue_bounce(b_issue_bounce),
    .issue_primary(b_issue_primary), .retire_valid(b_retire_valid), .retire_tag(b_retire_tag),
    .retire_miss(b_retire_miss), .busy(b_busy), .done(b_done));

  bit sel = 1'b0;
  logic             m_issue_valid, m_issue_primary, m_retire_valid, m_retire_miss, m_busy, m_done;
  logic [TAG_W-1:0] m_issue_tag, m_retire_tag;
  logic [3:0]       m_issue_bounce;
  assign m_issue_valid   = sel ? b_issue_valid   : a_issue_valid;
  assign m_issue_primary = sel ? b_issue_primary : a_issue_primary;
  assign m_issue_tag     = sel ? b_issue_tag     : a_issue_tag;
  assign m_issue_bounce  = sel ? b_issue_bounce  : a_issue_bounce;
  assign m_retire_valid  = sel ? b_retire_valid  : a_retire_valid;
  assign m_retire_tag    = sel ? b_retire_tag    : a_retire_tag;
  assign m_retire_miss   = sel ? b_retire_miss   : a_retire_miss;
  assign m_busy          = sel ? b_busy          : a_busy;
  assign m_done          = sel ? b_done          : a_done;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int tag; int bounce; int primary;} iss_t;
  typedef struct {int cyc; int tag; int miss;} ret_exp_t;
  typedef struct {int cyc; int tag; int bounce;} pend_t;

  iss_t     exp_issue[$];
  ret_exp_t exp_retire[$];
  int       exp_done[$];
  pend_t    pend[$];

  int passed = 0;
  int total  = 0;
  int lat = 1;
  int hit_mode = 0;
  int out_cnt = 0;
  int max_out = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit hit_for(input int tag, input int b);
    case (hit_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return (tag == 0 && b == 0);
    endcase
  endfunction

  task automatic push_issue(input int c, input int t, input int b, input int p);
    iss_t e;
    e.cyc = c; e.tag = t; e.bounce = b; e.primary = p;
    exp_issue.push_back(e);
  endtask

  task automatic push_retire(input int c, input int t, input int m);
    ret_exp_t e;
    e.cyc = c; e.tag = t; e.miss = m;
    exp_retire.push_back(e);
  endtask

  // Loop model: every issued ray comes back lat cycles later.
  initial begin
    ret_valid = 1'b0; ret_tag = '0; ret_bounce = '0; ret_hit = 1'b0;
    forever begin
      @(negedge clk);
      ret_valid = 1'b0;
      if (m_issue_valid) begin
        pend_t p;
        p.cyc = cyc + lat; p.tag = int'(m_issue_tag); p.bounce = int'(m_issue_bounce);
        pend.push_back(p);
      end
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i].cyc == cyc) begin
          ret_valid  = 1'b1;
          ret_tag    = TAG_W'(pend[i].tag);
          ret_bounce = 4'(pend[i].bounce);
          ret_hit    = hit_for(pend[i].tag, pend[i].bounce);
          pend.delete(i);
          break;
        end
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents an event.
  initial begin
    forever begin
      @(negedge clk);
      if (m_issue_valid) begin
        if (exp_issue.size() == 0) check("issue_unexpected", 1, 0);
        else begin
          iss_t e;
          e = exp_issue.pop_front();
          check("issue_cyc", cyc, e.cyc);
          check("issue_tag", int'(m_issue_tag), e.tag);
          check("issue_bounce", int'(m_issue_bounce), e.bounce);
          check("issue_primary", int'(m_issue_primary), e.primary);
        end
        if (m_issue_primary) out_cnt++;
        if (out_cnt > max_out) max_out = out_cnt;
      end
      if (m_retire_valid) begin
        if (exp_retire.size() == 0) check("retire_unexpected", 1, 0);
        else begin
          ret_exp_t e;
          e = exp_retire.pop_front();
          check("retire_cyc", cyc, e.cyc);
          check("retire_tag", int'(m_retire_tag), e.tag);
          check("retire_miss", int'(m_retire_miss), e.miss);
        end
        out_cnt--;
      end
      if (m_done) begin
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else check("done_cyc", cyc, exp_done.pop_front());
      end
    end
  end

  task automatic finish_test(input string name, input int budget);
    int n = 0;
    while ((exp_issue.size() + exp_retire.size() + exp_done.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({name, "_outstanding"}, exp_issue.size() + exp_retire.size() + exp_done.size(), 0);
    exp_issue.delete(); exp_retire.delete(); exp_done.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outs"}, int'({a_issue_valid, a_issue_primary, a_retire_valid, a_retire_miss,
                                 a_busy, a_done}), 0);
    check({name, "_issue_tag"}, int'(a_issue_tag), 0);
    check({name, "_issue_bounce"}, int'(a_issue_bounce), 0);
    check({name, "_retire_tag"}, int'(a_retire_tag), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; num_rays = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_a");
    check("reset_b_outs", int'({b_issue_valid, b_retire_valid, b_busy, b_done}), 0);
    rst = 1'b0;
    @(negedge clk);

    // One ray, always hits, 40-cycle loop: four passes then bounce-limit retirement.
    lat = 40; hit_mode = 1;
    @(negedge clk); s = cyc; start_a = 1'b1; num_rays = 16'd1;
    push_issue(s + 2, 0, 0, 1); push_issue(s + 43, 0, 1, 0);
    push_issue(s + 84, 0, 2, 0); push_issue(s + 125, 0, 3, 0);
    push_retire(s + 166, 0, 0); exp_done.push_back(s + 167);
    @(negedge clk); start_a = 1'b0;
    check("busy_run", int'(m_busy), 1);
    finish_test("bounce_limit", 300);
    check("busy_after_done", int'(m_busy), 0);

    // Three rays, all miss.
    lat = 5; hit_mode = 0;
    @(negedge clk); s = cyc; start_a = 1'b1; num_rays = 16'd3;
    push_issue(s + 2, 0, 0, 1); push_issue(s + 3, 1, 0, 1); push_issue(s + 4, 2, 0, 1);
    push_retire(s + 8, 0, 1); push_retire(s + 9, 1, 1); push_retire(s + 10, 2, 1);
    exp_done.push_back(s + 11);
    @(negedge clk); start_a = 1'b0;
    finish_test("all_miss", 100);

    // Reissue of tag 0 pre-empts the primary stream for one cycle.
    lat = 1; hit_mode = 2;
    @(negedge clk); s = cyc; start_a = 1'b1; num_rays = 16'd4;
    push_issue(s + 2, 0, 0, 1); push_issue(s + 3, 1, 0, 1); push_issue(s + 4, 0, 1, 0);
    push_issue(s + 5, 2, 0, 1); push_issue(s + 6, 3, 0, 1);
    push_retire(s + 5, 1, 1); push_retire(s + 6, 0, 1); push_retire(s + 7, 2, 1);
    push_retire(s + 8, 3, 1); exp_done.push_back(s + 9);
    @(negedge clk); start_a = 1'b0;
    finish_test("reissue_priority", 100);

    // In-flight limit of 2 on the second instance.
    sel = 1'b1; lat = 10; hit_mode = 0; out_cnt = 0; max_out = 0;
    @(negedge clk); s = cyc; start_b = 1'b1; num_rays = 16'd5;
    push_issue(s + 2, 0, 0, 1); push_issue(s + 3, 1, 0, 1); push_issue(s + 14, 2, 0, 1);
    push_issue(s + 15, 3, 0, 1); push_issue(s + 26, 4, 0, 1);
    push_retire(s + 13, 0, 1); push_retire(s + 14, 1, 1); push_retire(s + 25, 2, 1);
    push_retire(s + 26, 3, 1); push_retire(s + 37, 4, 1); exp_done.push_back(s + 38);
    @(negedge clk); start_b = 1'b0;
    finish_test("inflight_limit", 150);
    check("max_outstanding", max_out, 2);
    sel = 1'b0;

    // Reset mid-frame with three rays in flight; their returns must be ignored.
    lat = 20; hit_mode = 0;
    @(negedge clk); s = cyc; start_a = 1'b1; num_rays = 16'd5;
    push_issue(s + 2, 0, 0, 1); push_issue(s + 3, 1, 0, 1); push_issue(s + 4, 2, 0, 1);
    @(negedge clk); start_a = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_all_zero("midrst");
    while (cyc < s + 30) @(negedge clk);
    check_all_zero("stale_ret");
    check("stale_left", exp_issue.size(), 0);
    lat = 3;
    @(negedge clk); s = cyc; start_a = 1'b1; num_rays = 16'd1;
    push_issue(s + 2, 0, 0, 1); push_retire(s + 6, 0, 1); exp_done.push_back(s + 7);
    @(negedge clk); start_a = 1'b0;
    finish_test("after_rst", 100);

    // Empty frame completes at once without going busy.
    lat = 5;
    @(negedge clk); s = cyc; start_a = 1'b1; num_rays = 16'd0;
    exp_done.push_back(s + 1);
    @(negedge clk); start_a = 1'b0;
    check("busy_zero_frame_1", int'(m_busy), 0);
    @(negedge clk);
    check("busy_zero_frame_2", int'(m_busy), 0);
    finish_test("zero_rays", 20);

    // Start while running is ignored.
    @(negedge clk); s = cyc; start_a = 1'b1; num_rays = 16'd2;
    push_issue(s + 2, 0, 0, 1); push_issue(s + 3, 1, 0, 1);
    push_retire(s + 8, 0, 1); push_retire(s + 9, 1, 1); exp_done.push_back(s + 10);
    @(negedge clk); start_a = 1'b0;
    @(negedge clk); start_a = 1'b1; num_rays = 16'd7;
    @(negedge clk); start_a = 1'b0;
    finish_test("start_in_run", 100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ray_bounce_scheduler.md
RAY_BOUNCE_SCHEDULER -- requirements
Module: ray_bounce_scheduler

Interface
REQ-001 The block SHALL have parameter TAG_W, default 16, meaning the ray tag width and the frame ray-count width.
REQ-002 The block SHALL have parameter MAX_BOUNCES, default 4, meaning the number of trace/reflect passes a ray may make before forced retirement (legal range 1..15).
REQ-003 The block SHALL have parameter MAX_INFLIGHT, default 48, meaning the maximum number of rays simultaneously inside the non-stalling trace+reflect loop.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a frame.
REQ-007 num_rays  in  TAG_W  rays in frame; sampled on accepted start.
REQ-008 ret_valid  in  1  ray exiting reflector this cycle (reflect_done).
REQ-009 ret_tag  in  TAG_W  tag of returning ray.
REQ-010 ret_bounce  in  4  pass index the returning ray was issued with.
REQ-011 ret_hit  in  1  returning ray hit geometry (hit_valid).
REQ-012 issue_valid  out  1  ray issued into loop this cycle.
REQ-013 issue_tag  out  TAG_W  tag of issued ray.
REQ-014 issue_bounce  out  4  pass index of issued ray (0 = primary).
REQ-015 issue_primary  out  1  issued ray is new; caller loads camera ray instead of new_origin/new_dir.
REQ-016 retire_valid  out  1  ray finished; accumulated light is final.
REQ-017 retire_tag  out  TAG_W  tag of retired ray.
REQ-018 retire_miss  out  1  retirement caused by miss (0 = bounce limit).
REQ-019 busy  out  1  high in RUN and DRAIN.
REQ-020 done  out  1  one-cycle pulse when every ray of the frame has retired.

Function
REQ-021 The FSM SHALL have states IDLE, RUN, DRAIN.
REQ-022 IDLE: start with num_rays!=0 SHALL latch num_rays, clear issue/retire counters and the in-flight count, and go to RUN; start with num_rays==0 SHALL pulse done next cycle and stay in IDLE.
REQ-023 start in RUN or DRAIN SHALL be ignored.
REQ-024 All outputs except busy SHALL be registered: a return seen at cycle t SHALL produce its reissue or retirement at cycle t+1.
REQ-025 A return with ret_hit=1 and ret_bounce+1 < MAX_BOUNCES SHALL be reissued with the same tag, issue_bounce=ret_bounce+1, issue_primary=0.
REQ-026 A return with ret_hit=0 SHALL retire with retire_miss=1; a hit with ret_bounce+1 >= MAX_BOUNCES SHALL retire with retire_miss=0.
REQ-027 Reissue SHALL have strict priority over a new primary ray; at most one issue per cycle.
REQ-028 In RUN, a primary ray SHALL issue in a cycle with no reissue only when issued_count < num_rays and inflight < MAX_INFLIGHT; tags SHALL be issued_count, sequential from 0.
REQ-029 inflight SHALL increment on a primary issue, decrement on a retirement, be unchanged on a reissue, and be unchanged when a primary issue and a retirement coincide.
REQ-030 RUN SHALL go to DRAIN in the cycle after issued_count reaches num_rays.
REQ-031 DRAIN SHALL go to IDLE and pulse done in the cycle after the retirement that makes retired_count equal num_rays.
REQ-032 ret_valid in IDLE SHALL be ignored (no issue, no retire).
REQ-033 Counters SHALL be TAG_W+1 bits so num_rays = 2^TAG_W-1 never wraps.

Reset
REQ-034 On rst: state IDLE; all counters, inflight, issue_valid, retire_valid, done, busy = 0; issue_tag, issue_bounce, retire_tag = 0.
REQ-035 rst SHALL take effect mid-frame on the next edge, discarding all in-flight rays; their later returns SHALL be ignored per REQ-032.

Verification
REQ-036 MAX_BOUNCES=4, num_rays=1, loop model latency 40 always hit -> issues tag 0 at bounce 0,1,2,3 spaced 41 cycles, one retire_miss=0, done pulses one cycle after the retire.
REQ-037 num_rays=3, all miss -> primaries tags 0,1,2 in consecutive cycles, three retire_miss=1, done once.
REQ-038 Return with hit and ret_bounce=0 arriving while primaries remain -> next cycle issue_primary=0, issue_bounce=1; primary tag stream resumes the following cycle with no tag skipped.
REQ-039 MAX_INFLIGHT=2, num_rays=5, latency 10 -> never more than 2 outstanding; issue resumes the cycle after each retirement.
REQ-040 rst asserted at inflight=3 in RUN, then stale returns -> all outputs 0, no issue/retire/done; a new start with num_rays=1 runs normally.
REQ-041 start with num_rays=0 -> done pulse next cycle, busy never asserts; start during RUN -> no effect on num_rays or counters.
